// File: rtl/msdap_ctrl_multi_if.sv
// msdap_ctrl_multi_if: bundle between the serial-input side and the MSDAP main controller.
// master = serial-input/datapath side, slave = controller.
interface msdap_ctrl_multi_if #(
   parameter int NUM_CH      = 2,
   parameter int RJ_DEPTH    = 16,
   parameter int COEFF_DEPTH = 512,
   parameter int DATA_DEPTH  = 256
);
   localparam int RJ_AW = $clog2(RJ_DEPTH);
   localparam int CF_AW = $clog2(COEFF_DEPTH);
   localparam int DA_AW = $clog2(DATA_DEPTH);

   logic              Frame;
   logic              input_rdy;
   logic [NUM_CH-1:0] in_zero;
   logic              Flush;
   logic [NUM_CH-1:0] OutReady_ch;
   logic [RJ_AW-1:0]  rj_wr_addr;
   logic [CF_AW-1:0]  coeff_wr_addr;
   logic [DA_AW-1:0]  data_wr_addr;
   logic              rj_en;
   logic              coeff_en;
   logic              data_en;
   logic              Clear;
   logic              compute_enable;
   logic              sleep_flag;
   logic              InReady;
   logic              OutReady;
   logic [3:0]        state;
   logic [15:0]       sample_count;

   modport master (
      output Frame, input_rdy, in_zero, Flush, OutReady_ch,
      input  rj_wr_addr, coeff_wr_addr, data_wr_addr, rj_en, coeff_en, data_en,
             Clear, compute_enable, sleep_flag, InReady, OutReady, state, sample_count
   );

   modport slave (
      input  Frame, input_rdy, in_zero, Flush, OutReady_ch,
      output rj_wr_addr, coeff_wr_addr, data_wr_addr, rj_en, coeff_en, data_en,
             Clear, compute_enable, sleep_flag, InReady, OutReady, state, sample_count
   );
endinterface

// File: rtl/msdap_ctrl_multi.sv
// msdap_ctrl_multi: loads rj/coeff tables, streams samples into a circular buffer, zero-run sleep, flush.
// Define MSDAP_SAMPLE_CNT_EN to build the saturating data-write counter on sample_count.
module msdap_ctrl_multi #(
   parameter int NUM_CH      = 2,
   parameter int RJ_DEPTH    = 16,
   parameter int COEFF_DEPTH = 512,
   parameter int DATA_DEPTH  = 256,
   parameter int ZERO_RUN    = 800
) (
   input logic               Sclk,
   input logic               Reset,
   msdap_ctrl_multi_if.slave bus
);
   localparam int RJ_AW = $clog2(RJ_DEPTH);
   localparam int CF_AW = $clog2(COEFF_DEPTH);
   localparam int DA_AW = $clog2(DATA_DEPTH);
   localparam int ZW    = $clog2(ZERO_RUN + 1);

   localparam logic [RJ_AW:0]  RJ_FULL = (RJ_AW + 1)'(RJ_DEPTH);
   localparam logic [CF_AW:0]  CF_FULL = (CF_AW + 1)'(COEFF_DEPTH);
   localparam logic [ZW-1:0]   ZR_MAX  = ZW'(ZERO_RUN);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_WAIT_RJ    = 4'd1,
      ST_READ_RJ    = 4'd2,
      ST_WAIT_COEFF = 4'd3,
      ST_READ_COEFF = 4'd4,
      ST_WAIT_INPUT = 4'd5,
      ST_COMPUTE    = 4'd6,
      ST_SLEEP      = 4'd7,
      ST_FLUSH      = 4'd8
   } state_t;

   state_t                   state_r;
   state_t                   next_s;
   logic                     clear_r;
   logic                     in_ready_r;
   logic                     sleep_r;
   logic                     clear_s;
   logic                     in_ready_s;
   logic                     sleep_s;

   logic                     input_rdy_q;
   logic                     accept_s;
   logic                     all_sat_s;
   logic                     any_live_s;
   logic                     wr_rj_s;
   logic                     wr_coeff_s;
   logic                     wr_data_s;

   logic [RJ_AW:0]           rj_cnt_r;
   logic [CF_AW:0]           coeff_cnt_r;
   logic [DA_AW-1:0]         data_ptr_r;
   logic [RJ_AW-1:0]         rj_addr_r;
   logic [CF_AW-1:0]         coeff_addr_r;
   logic [DA_AW-1:0]         data_addr_r;
   logic                     rj_en_r;
   logic                     coeff_en_r;
   logic                     data_en_r;
   logic [NUM_CH-1:0][ZW-1:0] zrun_r;

   function automatic logic [ZW-1:0] zrun_step(input logic [ZW-1:0] cnt, input logic zero);
      if (!zero)
         return '0;
      else if (cnt == ZR_MAX)
         return cnt;
      else
         return cnt + ZW'(1);
   endfunction

   assign accept_s   = bus.input_rdy & ~input_rdy_q;
   assign any_live_s = ~(&bus.in_zero);

   // Sleep is only entered when every channel has already seen a full zero run.
   always_comb begin
      all_sat_s = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++)
         all_sat_s = all_sat_s & (zrun_r[ch] == ZR_MAX);
   end

   // State register; Moore outputs are registered from the next state.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         clear_r    <= 1'b1;
         in_ready_r <= 1'b0;
         sleep_r    <= 1'b0;
      end else begin
         state_r    <= next_s;
         clear_r    <= clear_s;
         in_ready_r <= in_ready_s;
         sleep_r    <= sleep_s;
      end
   end

   // Next-state logic; Flush beats an accept in the same cycle.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE:       next_s = ST_WAIT_RJ;
         ST_WAIT_RJ:    next_s = bus.Frame ? ST_READ_RJ : ST_WAIT_RJ;
         ST_READ_RJ:    next_s = (rj_cnt_r == RJ_FULL) ? ST_WAIT_COEFF : ST_READ_RJ;
         ST_WAIT_COEFF: next_s = bus.Frame ? ST_READ_COEFF : ST_WAIT_COEFF;
         ST_READ_COEFF: next_s = (coeff_cnt_r == CF_FULL) ? ST_WAIT_INPUT : ST_READ_COEFF;
         ST_WAIT_INPUT: begin
            if (bus.Flush)
               next_s = ST_FLUSH;
            else if (bus.Frame)
               next_s = ST_COMPUTE;
            else
               next_s = ST_WAIT_INPUT;
         end
         ST_COMPUTE: begin
            if (bus.Flush)
               next_s = ST_FLUSH;
            else if (accept_s && all_sat_s)
               next_s = ST_SLEEP;
            else
               next_s = ST_COMPUTE;
         end
         ST_SLEEP: begin
            if (bus.Flush)
               next_s = ST_FLUSH;
            else if (accept_s && any_live_s)
               next_s = ST_COMPUTE;
            else
               next_s = ST_SLEEP;
         end
         ST_FLUSH:      next_s = bus.Flush ? ST_FLUSH : ST_WAIT_INPUT;
         default:       next_s = ST_IDLE;
      endcase
   end

   // Output decode: write requests from the current state, Moore flags from the next state.
   always_comb begin
      wr_rj_s    = 1'b0;
      wr_coeff_s = 1'b0;
      wr_data_s  = 1'b0;
      case (state_r)
         ST_READ_RJ:    wr_rj_s    = accept_s & (rj_cnt_r != RJ_FULL);
         ST_READ_COEFF: wr_coeff_s = accept_s & (coeff_cnt_r != CF_FULL);
         ST_COMPUTE:    wr_data_s  = accept_s & ~bus.Flush & ~all_sat_s;
         ST_SLEEP:      wr_data_s  = accept_s & ~bus.Flush & any_live_s;
         default:       wr_data_s  = 1'b0;
      endcase
      clear_s    = (next_s == ST_IDLE) || (next_s == ST_FLUSH);
      in_ready_s = (next_s != ST_IDLE) && (next_s != ST_FLUSH);
      sleep_s    = (next_s == ST_SLEEP);
   end

   // Datapath: edge detect, load counters, write strobes/addresses, zero-run counters.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         input_rdy_q  <= 1'b0;
         rj_cnt_r     <= '0;
         coeff_cnt_r  <= '0;
         data_ptr_r   <= '0;
         rj_addr_r    <= '0;
         coeff_addr_r <= '0;
         data_addr_r  <= '0;
         rj_en_r      <= 1'b0;
         coeff_en_r   <= 1'b0;
         data_en_r    <= 1'b0;
         zrun_r       <= '0;
      end else begin
         input_rdy_q <= bus.input_rdy;
         rj_en_r     <= wr_rj_s;
         coeff_en_r  <= wr_coeff_s;
         data_en_r   <= wr_data_s;

         if (state_r == ST_IDLE) begin
            rj_cnt_r    <= '0;
            coeff_cnt_r <= '0;
         end
         if (wr_rj_s) begin
            rj_addr_r <= rj_cnt_r[RJ_AW-1:0];
            rj_cnt_r  <= rj_cnt_r + (RJ_AW + 1)'(1);
         end
         if (wr_coeff_s) begin
            coeff_addr_r <= coeff_cnt_r[CF_AW-1:0];
            coeff_cnt_r  <= coeff_cnt_r + (CF_AW + 1)'(1);
         end
         if (next_s == ST_WAIT_INPUT) begin
            rj_addr_r    <= '0;
            coeff_addr_r <= '0;
         end

         if (next_s == ST_FLUSH) begin
            data_ptr_r  <= '0;
            data_addr_r <= '0;
         end else if (wr_data_s) begin
            data_addr_r <= data_ptr_r;
            data_ptr_r  <= data_ptr_r + DA_AW'(1);
         end

         if (next_s == ST_FLUSH || state_r == ST_IDLE) begin
            zrun_r <= '0;
         end else if (accept_s && state_r == ST_COMPUTE) begin
            for (int ch = 0; ch < NUM_CH; ch++)
               zrun_r[ch] <= zrun_step(zrun_r[ch], bus.in_zero[ch]);
         end else if (accept_s && state_r == ST_SLEEP && any_live_s) begin
            zrun_r <= '0;
         end
      end
   end

`ifdef MSDAP_SAMPLE_CNT_EN
   logic [15:0] sample_cnt_r;

   // Data-write counter, saturating; only the hard reset clears it.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset)
         sample_cnt_r <= 16'd0;
      else if (wr_data_s && (sample_cnt_r != 16'hFFFF))
         sample_cnt_r <= sample_cnt_r + 16'd1;
   end

   assign bus.sample_count = sample_cnt_r;
`else
   assign bus.sample_count = 16'd0;
`endif

   assign bus.rj_wr_addr     = rj_addr_r;
   assign bus.coeff_wr_addr  = coeff_addr_r;
   assign bus.data_wr_addr   = data_addr_r;
   assign bus.rj_en          = rj_en_r;
   assign bus.coeff_en       = coeff_en_r;
   assign bus.data_en        = data_en_r;
   assign bus.compute_enable = data_en_r;
   assign bus.Clear          = clear_r;
   assign bus.InReady        = in_ready_r;
   assign bus.sleep_flag     = sleep_r;
   assign bus.state          = state_r;
   assign bus.OutReady       = |bus.OutReady_ch;
endmodule

// File: tb/tb_msdap_ctrl_multi.sv
// tb_msdap_ctrl_multi: directed bench for msdap_ctrl_multi at default parameters.
module tb_msdap_ctrl_multi;
   logic Sclk = 1'b0;
   logic Reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;

   msdap_ctrl_multi_if #(.NUM_CH(2), .RJ_DEPTH(16), .COEFF_DEPTH(512), .DATA_DEPTH(256)) bus ();

   msdap_ctrl_multi #(
      .NUM_CH(2), .RJ_DEPTH(16), .COEFF_DEPTH(512), .DATA_DEPTH(256), .ZERO_RUN(800)
   ) dut (
      .Sclk  (Sclk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Sclk = ~Sclk;

   function automatic logic [15:0] exp_samples();
`ifdef MSDAP_SAMPLE_CNT_EN
      return exp_cnt[15:0];
`else
      return 16'd0;
`endif
   endfunction

   task automatic frame_pulse();
      @(negedge Sclk); bus.Frame = 1'b1;
      @(negedge Sclk); bus.Frame = 1'b0;
   endtask

   // One word: input_rdy high for one cycle; returns in the cycle the strobe is visible.
   task automatic send(input logic [1:0] z);
      @(negedge Sclk); bus.in_zero = z; bus.input_rdy = 1'b1;
      @(negedge Sclk); bus.input_rdy = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_chk++; if (bus.state !== 4'd0 || bus.Clear !== 1'b1 || bus.InReady !== 1'b0 || bus.sleep_flag !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: state=%0d Clear=%b InReady=%b sleep=%b, need 0/1/0/0", bus.state, bus.Clear, bus.InReady, bus.sleep_flag); end
      n_chk++; if ({bus.rj_wr_addr, bus.coeff_wr_addr, bus.data_wr_addr} !== 21'd0 || {bus.rj_en, bus.coeff_en, bus.data_en, bus.compute_enable} !== 4'd0 || bus.sample_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_outputs: addr=%0d/%0d/%0d en=%b%b%b ce=%b cnt=%0d, need all 0", bus.rj_wr_addr, bus.coeff_wr_addr, bus.data_wr_addr, bus.rj_en, bus.coeff_en, bus.data_en, bus.compute_enable, bus.sample_count); end
      bus.OutReady_ch = 2'b10; #1;
      n_chk++; if (bus.OutReady !== 1'b1) begin n_fail++; $display("FAIL outready_or: got %b need 1", bus.OutReady); end
      bus.OutReady_ch = 2'b00; #1;
      n_chk++; if (bus.OutReady !== 1'b0) begin n_fail++; $display("FAIL outready_none: got %b need 0", bus.OutReady); end
      @(negedge Sclk); Reset = 1'b0;
      @(negedge Sclk);
      n_chk++; if (bus.state !== 4'd1 || bus.InReady !== 1'b1 || bus.Clear !== 1'b0) begin
         n_fail++; $display("FAIL after_idle: state=%0d InReady=%b Clear=%b, need 1/1/0", bus.state, bus.InReady, bus.Clear); end
   endtask

   task automatic test_rj_load();
      frame_pulse();
      n_chk++; if (bus.state !== 4'd2) begin n_fail++; $display("FAIL rj_frame: state=%0d need 2", bus.state); end
      for (int i = 0; i < 16; i++) begin
         send(2'b00);
         n_chk++; if (bus.rj_en !== 1'b1 || bus.rj_wr_addr !== 4'(i) || bus.coeff_en !== 1'b0) begin
            n_fail++; $display("FAIL rj_write[%0d]: en=%b addr=%0d coeff_en=%b, need 1/%0d/0", i, bus.rj_en, bus.rj_wr_addr, bus.coeff_en, i); end
      end
      @(negedge Sclk);
      n_chk++; if (bus.rj_en !== 1'b0 || bus.state !== 4'd3) begin
         n_fail++; $display("FAIL rj_done: en=%b state=%0d, need 0/3", bus.rj_en, bus.state); end
      send(2'b00);
      n_chk++; if (bus.rj_en !== 1'b0 || bus.state !== 4'd3) begin
         n_fail++; $display("FAIL rj_17th: en=%b state=%0d, need 0/3", bus.rj_en, bus.state); end
   endtask

   task automatic test_coeff_load();
      frame_pulse();
      n_chk++; if (bus.state !== 4'd4) begin n_fail++; $display("FAIL coeff_frame: state=%0d need 4", bus.state); end
      for (int i = 0; i < 512; i++) begin
         send(2'b00);
         n_chk++; if (bus.coeff_en !== 1'b1 || bus.coeff_wr_addr !== 9'(i) || bus.rj_en !== 1'b0) begin
            n_fail++; $display("FAIL coeff_write[%0d]: en=%b addr=%0d rj_en=%b, need 1/%0d/0", i, bus.coeff_en, bus.coeff_wr_addr, bus.rj_en, i); end
      end
      @(negedge Sclk);
      n_chk++; if (bus.state !== 4'd5 || bus.coeff_en !== 1'b0 || bus.coeff_wr_addr !== 9'd0 || bus.rj_wr_addr !== 4'd0 || bus.InReady !== 1'b1) begin
         n_fail++; $display("FAIL coeff_done: state=%0d en=%b caddr=%0d raddr=%0d InReady=%b, need 5/0/0/0/1", bus.state, bus.coeff_en, bus.coeff_wr_addr, bus.rj_wr_addr, bus.InReady); end
   endtask

   task automatic test_data_wrap();
      int ce_seen = 0;
      frame_pulse();
      n_chk++; if (bus.state !== 4'd6) begin n_fail++; $display("FAIL compute_frame: state=%0d need 6", bus.state); end
      for (int i = 0; i < 300; i++) begin
         send(2'b00);
         exp_cnt++;
         if (bus.compute_enable === 1'b1) ce_seen++;
         n_chk++; if (bus.data_en !== 1'b1 || bus.data_wr_addr !== 8'(i % 256)) begin
            n_fail++; $display("FAIL data_write[%0d]: en=%b addr=%0d, need 1/%0d", i, bus.data_en, bus.data_wr_addr, i % 256); end
         if (i == 0) begin
            @(negedge Sclk);
            n_chk++; if (bus.data_en !== 1'b0 || bus.compute_enable !== 1'b0) begin
               n_fail++; $display("FAIL strobe_width: data_en=%b ce=%b one cycle later, need 0/0", bus.data_en, bus.compute_enable); end
         end
      end
      n_chk++; if (ce_seen != 300) begin n_fail++; $display("FAIL compute_pulses: got %0d need 300", ce_seen); end
      n_chk++; if (bus.sample_count !== exp_samples()) begin
         n_fail++; $display("FAIL count_after_wrap: got %0d need %0d", bus.sample_count, exp_samples()); end
   endtask

   task automatic test_sleep();
      for (int i = 0; i < 800; i++) begin
         send(2'b11);
         exp_cnt++;
         n_chk++; if (bus.data_en !== 1'b1 || bus.data_wr_addr !== 8'((300 + i) % 256)) begin
            n_fail++; $display("FAIL zero_write[%0d]: en=%b addr=%0d, need 1/%0d", i, bus.data_en, bus.data_wr_addr, (300 + i) % 256); end
      end
      send(2'b11);
      n_chk++; if (bus.data_en !== 1'b0 || bus.compute_enable !== 1'b0 || bus.state !== 4'd7 || bus.sleep_flag !== 1'b1) begin
         n_fail++; $display("FAIL sleep_enter: en=%b ce=%b state=%0d sleep=%b, need 0/0/7/1", bus.data_en, bus.compute_enable, bus.state, bus.sleep_flag); end
      send(2'b11);
      n_chk++; if (bus.data_en !== 1'b0 || bus.state !== 4'd7) begin
         n_fail++; $display("FAIL sleep_stay: en=%b state=%0d, need 0/7", bus.data_en, bus.state); end
      send(2'b01);
      exp_cnt++;
      n_chk++; if (bus.data_en !== 1'b1 || bus.compute_enable !== 1'b1 || bus.state !== 4'd6 || bus.sleep_flag !== 1'b0 || bus.data_wr_addr !== 8'd76) begin
         n_fail++; $display("FAIL wake: en=%b ce=%b state=%0d sleep=%b addr=%0d, need 1/1/6/0/76", bus.data_en, bus.compute_enable, bus.state, bus.sleep_flag, bus.data_wr_addr); end
      n_chk++; if (bus.sample_count !== exp_samples()) begin
         n_fail++; $display("FAIL count_after_wake: got %0d need %0d", bus.sample_count, exp_samples()); end
   endtask

   task automatic test_flush();
      @(negedge Sclk); bus.Flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Sclk);
         n_chk++; if (bus.state !== 4'd8 || bus.Clear !== 1'b1 || bus.InReady !== 1'b0 || bus.data_wr_addr !== 8'd0 || bus.sleep_flag !== 1'b0) begin
            n_fail++; $display("FAIL flush_hold[%0d]: state=%0d Clear=%b InReady=%b addr=%0d sleep=%b, need 8/1/0/0/0", k, bus.state, bus.Clear, bus.InReady, bus.data_wr_addr, bus.sleep_flag); end
      end
      bus.Flush = 1'b0;
      @(negedge Sclk);
      n_chk++; if (bus.state !== 4'd5 || bus.Clear !== 1'b0 || bus.InReady !== 1'b1) begin
         n_fail++; $display("FAIL flush_release: state=%0d Clear=%b InReady=%b, need 5/0/1", bus.state, bus.Clear, bus.InReady); end
      frame_pulse();
      send(2'b00);
      exp_cnt++;
      n_chk++; if (bus.data_en !== 1'b1 || bus.data_wr_addr !== 8'd0 || bus.rj_en !== 1'b0 || bus.coeff_en !== 1'b0 || bus.state !== 4'd6) begin
         n_fail++; $display("FAIL post_flush_write: en=%b addr=%0d rj=%b coeff=%b state=%0d, need 1/0/0/0/6", bus.data_en, bus.data_wr_addr, bus.rj_en, bus.coeff_en, bus.state); end
   endtask

   task automatic test_flush_accept();
      @(negedge Sclk); bus.Flush = 1'b1; bus.in_zero = 2'b00; bus.input_rdy = 1'b1;
      @(negedge Sclk);
      n_chk++; if (bus.data_en !== 1'b0 || bus.compute_enable !== 1'b0 || bus.state !== 4'd8) begin
         n_fail++; $display("FAIL flush_vs_accept: en=%b ce=%b state=%0d, need 0/0/8", bus.data_en, bus.compute_enable, bus.state); end
      n_chk++; if (bus.sample_count !== exp_samples()) begin
         n_fail++; $display("FAIL count_over_flush: got %0d need %0d", bus.sample_count, exp_samples()); end
      bus.Flush = 1'b0; bus.input_rdy = 1'b0;
      @(negedge Sclk);
      n_chk++; if (bus.state !== 4'd5) begin n_fail++; $display("FAIL flush_accept_exit: state=%0d need 5", bus.state); end
   endtask

   task automatic test_async_reset();
      @(negedge Sclk); Reset = 1'b1;
      @(negedge Sclk); Reset = 1'b0;
      exp_cnt = 0;
      @(negedge Sclk);
      frame_pulse();
      for (int i = 0; i < 16; i++) send(2'b00);
      @(negedge Sclk);
      frame_pulse();
      for (int i = 0; i < 10; i++) send(2'b00);
      @(negedge Sclk); bus.input_rdy = 1'b1;
      @(posedge Sclk); #3;
      n_chk++; if (bus.coeff_en !== 1'b1 || bus.coeff_wr_addr !== 9'd10 || bus.state !== 4'd4) begin
         n_fail++; $display("FAIL mid_coeff: en=%b addr=%0d state=%0d, need 1/10/4", bus.coeff_en, bus.coeff_wr_addr, bus.state); end
      Reset = 1'b1; #1;
      n_chk++; if (bus.state !== 4'd0 || bus.coeff_en !== 1'b0 || bus.coeff_wr_addr !== 9'd0 || bus.rj_wr_addr !== 4'd0 || bus.Clear !== 1'b1 || bus.InReady !== 1'b0 || bus.sample_count !== 16'd0) begin
         n_fail++; $display("FAIL async_reset: state=%0d en=%b caddr=%0d raddr=%0d Clear=%b InReady=%b cnt=%0d, need 0/0/0/0/1/0/0", bus.state, bus.coeff_en, bus.coeff_wr_addr, bus.rj_wr_addr, bus.Clear, bus.InReady, bus.sample_count); end
      @(negedge Sclk); bus.input_rdy = 1'b0;
      @(negedge Sclk); Reset = 1'b0;
      @(negedge Sclk);
      n_chk++; if (bus.state !== 4'd1) begin n_fail++; $display("FAIL reload_wait: state=%0d need 1", bus.state); end
      frame_pulse();
      send(2'b00);
      n_chk++; if (bus.rj_en !== 1'b1 || bus.rj_wr_addr !== 4'd0) begin
         n_fail++; $display("FAIL reload_first: en=%b addr=%0d, need 1/0", bus.rj_en, bus.rj_wr_addr); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      Reset           = 1'b1;
      bus.Frame       = 1'b0;
      bus.input_rdy   = 1'b0;
      bus.in_zero     = 2'b00;
      bus.Flush       = 1'b0;
      bus.OutReady_ch = 2'b00;
      test_reset();
      test_rj_load();
      test_coeff_load();
      test_data_wrap();
      test_sleep();
      test_flush();
      test_flush_accept();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
